// File: rtl/semi_pkg.sv
// Shared types and the 3:3:3 master palette for the semigraphics renderer.
package semi_pkg;

  typedef enum logic {
    SG4 = 1'b0,
    SG6 = 1'b1
  } mode_e;

  typedef struct packed {
    logic [1:0] pattern;  // [1] = left half, [0] = right half
    logic [2:0] pal_idx;
  } cell_t;

  // Entries 0..7: green, yellow, blue, red, buff, cyan, magenta, orange (R in [8:6]).
  localparam logic [7:0][8:0] Palette333 = {
    9'h1E0, 9'h1C7, 9'h03F, 9'h1FE, 9'h1C0, 9'h007, 9'h1F8, 9'h038
  };

endpackage

// File: rtl/semi_render_if.sv
// Fetch-side bus of the semigraphics renderer: cell input, pixel enable and status outputs.
interface semi_render_if #(
  parameter int unsigned ROWS_PER_CELL = 12,
  parameter int unsigned RGB_W         = 9,
  localparam int unsigned RowW         = $clog2(ROWS_PER_CELL)
);
  logic [7:0]      inData;
  logic [RowW-1:0] row;
  logic            mode;
  logic            css;
  logic            load;
  logic            divider;
  logic [RGB_W-1:0] rgb;
  logic            active;
  logic            ready;
  logic            overrun;

  modport master (
    output inData, row, mode, css, load, divider,
    input  rgb, active, ready, overrun
  );

  modport slave (
    input  inData, row, mode, css, load, divider,
    output rgb, active, ready, overrun
  );
endinterface

// File: rtl/semi_decode.sv
// Combinational cell-byte/row/mode decode into a half-cell pattern and palette index.
// SG6 decode is only built when SEMI_SG6_EN is defined.
module semi_decode
  import semi_pkg::*;
#(
  parameter int unsigned ROWS_PER_CELL = 12,
  localparam int unsigned RowW         = $clog2(ROWS_PER_CELL)
) (
  input  logic [7:0]      data_i,
  input  logic [RowW-1:0] row_i,
  input  logic            mode_i,
  input  logic            css_i,
  output cell_t           cell_o
);

  localparam int unsigned Half  = ROWS_PER_CELL / 2;
  localparam int unsigned Third = ROWS_PER_CELL / 3;

  logic [31:0] row_w;

  always_comb begin
    row_w  = 32'(row_i);
    cell_o = '0;
`ifdef SEMI_SG6_EN
    if (mode_e'(mode_i) == SG6) begin
      cell_o.pal_idx = {css_i, data_i[7:6]};
      if (row_w < Third) begin
        cell_o.pattern = data_i[5:4];
      end else if (row_w < 2 * Third) begin
        cell_o.pattern = data_i[3:2];
      end else begin
        cell_o.pattern = data_i[1:0];
      end
    end else
`endif
    begin
      cell_o.pal_idx = data_i[6:4];
      cell_o.pattern = (row_w < Half) ? data_i[3:2] : data_i[1:0];
    end
    // Out-of-range rows still render (active) but in black.
    if (row_w >= ROWS_PER_CELL) begin
      cell_o.pattern = 2'b00;
    end
  end

`ifndef SEMI_SG6_EN
  logic unused_sg6;
  assign unused_sg6 = mode_i ^ css_i ^ data_i[7];
`endif

endmodule

// File: rtl/semi_render.sv
// Semigraphics renderer: holding register + pixel serialiser driving the RGB output.
// Optional SG6 decode is enabled with SEMI_SG6_EN.
module semi_render
  import semi_pkg::*;
#(
  parameter int unsigned PIX_PER_CELL  = 8,
  parameter int unsigned ROWS_PER_CELL = 12,
  parameter int unsigned RGB_W         = 9
) (
  input logic         clk,
  input logic         reset_n,
  semi_render_if.slave bus
);

  localparam int unsigned CntW = $clog2(PIX_PER_CELL);
  localparam int unsigned ChW  = RGB_W / 3;

  // Each 3-bit channel is widened/narrowed by MSB-first bit replication.
  logic [7:0][RGB_W-1:0] pal_rgb;
  for (genvar gp = 0; gp < 8; gp++) begin : g_pal
    for (genvar gc = 0; gc < 3; gc++) begin : g_ch
      for (genvar gk = 0; gk < ChW; gk++) begin : g_bit
        assign pal_rgb[gp][gc*ChW + ChW - 1 - gk] = Palette333[gp][gc*3 + 2 - (gk % 3)];
      end
    end
  end

  cell_t            dec_cell, hold_q, hold_d, shift_q, shift_d;
  logic             hold_v_q, hold_v_d, overrun_q, overrun_d, active_q, active_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             xfer;

  semi_decode #(
    .ROWS_PER_CELL(ROWS_PER_CELL)
  ) u_decode (
    .data_i(bus.inData),
    .row_i (bus.row),
    .mode_i(bus.mode),
    .css_i (bus.css),
    .cell_o(dec_cell)
  );

  function automatic logic [RGB_W-1:0] pix_color(cell_t c, int unsigned idx);
    logic on;
    on = (idx < PIX_PER_CELL / 2) ? c.pattern[1] : c.pattern[0];
    return on ? pal_rgb[c.pal_idx] : '0;
  endfunction

  always_comb begin
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    shift_d   = shift_q;
    count_d   = count_q;
    rgb_d     = rgb_q;
    active_d  = active_q;
    overrun_d = overrun_q;
    xfer      = bus.divider && (count_q == '0) && hold_v_q;

    if (bus.divider) begin
      if (count_q != '0) begin
        rgb_d    = pix_color(shift_q, PIX_PER_CELL - 32'(count_q));
        active_d = 1'b1;
        count_d  = count_q - CntW'(1);
      end else if (hold_v_q) begin
        shift_d  = hold_q;
        rgb_d    = pix_color(hold_q, 0);
        active_d = 1'b1;
        count_d  = CntW'(PIX_PER_CELL - 1);
      end else begin
        rgb_d    = '0;
        active_d = 1'b0;
      end
    end

    if (xfer) begin
      hold_v_d = 1'b0;
    end
    // A load coinciding with a transfer refills the slot without counting as overrun.
    if (bus.load) begin
      hold_d   = dec_cell;
      hold_v_d = 1'b1;
      if (hold_v_q && !xfer) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      shift_q   <= '0;
      count_q   <= '0;
      rgb_q     <= '0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      rgb_q     <= rgb_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.rgb     = rgb_q;
  assign bus.active  = active_q;
  assign bus.ready   = !hold_v_q;
  assign bus.overrun = overrun_q;

endmodule
